moore_binary_counter: RTL and testbench



---
 rtl/moore_binary_counter_pkg.sv | 10 +
 rtl/d_ff_sync_rstn.sv | 21 ++
 rtl/moore_binary_counter_beh.sv | 30 +++
 rtl/moore_binary_counter_str.sv | 25 ++
 rtl/moore_binary_counter.sv | 31 +++
 tb/tb_moore_binary_counter.sv | 86 ++++++++
 6 files changed

// File: rtl/moore_binary_counter_pkg.sv
// moore_binary_counter_pkg: shared state encoding for the 2-bit Moore counter.
//   S0..S3 encode the state as {A,B}.
package moore_binary_counter_pkg;
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;
endpackage

// File: rtl/d_ff_sync_rstn.sv
// d_ff_sync_rstn: D flip-flop with synchronous active-low reset.
//   clk  : rising-edge clock
//   rstn : synchronous reset, active low, clears q
//   d    : data in
//   q    : registered data out
module d_ff_sync_rstn (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic q_q;
    logic q_d;
    always_comb begin
        q_d = rstn ? d : 1'b0;
    end
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/moore_binary_counter_beh.sv
// moore_binary_counter_beh: behavioural 2-bit Moore up-counter with count enable.
//   rstn  : synchronous reset, active low, forces S0
//   clk   : rising-edge clock
//   x_in  : count enable; advance one state per edge when high
//   y_out : high only in S3
module moore_binary_counter_beh
    import moore_binary_counter_pkg::*;
(
    input  logic rstn,
    input  logic clk,
    input  logic x_in,
    output logic y_out
);
    state_t state_q;
    state_t state_d;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:      state_d = x_in ? S1 : S0;
            S1:      state_d = x_in ? S2 : S1;
            S2:      state_d = x_in ? S3 : S2;
            S3:      state_d = x_in ? S0 : S3;
            default: state_d = S0;
        endcase
    end
    always_ff @(posedge clk) begin
        state_q <= rstn ? state_d : S0;
    end
    assign y_out = (state_q == S3);
endmodule

// File: rtl/moore_binary_counter_str.sv
// moore_binary_counter_str: gate-level 2-bit Moore up-counter built from two D flip-flops.
//   rstn  : synchronous reset, active low, clears A and B
//   clk   : rising-edge clock
//   x_in  : count enable
//   y_out : A & B
//   A, B  : state MSB and LSB
module moore_binary_counter_str (
    input  logic rstn,
    input  logic clk,
    input  logic x_in,
    output logic y_out,
    output logic A,
    output logic B
);
    logic carry;
    logic a_d;
    logic b_d;
    // A toggles only when the LSB carries out, i.e. B=1 and counting.
    and g_carry (carry, B, x_in);
    xor g_a (a_d, A, carry);
    xor g_b (b_d, B, x_in);
    and g_y (y_out, A, B);
    d_ff_sync_rstn u_ff_a (.clk(clk), .rstn(rstn), .d(a_d), .q(A));
    d_ff_sync_rstn u_ff_b (.clk(clk), .rstn(rstn), .d(b_d), .q(B));
endmodule

// File: rtl/moore_binary_counter.sv
// moore_binary_counter: runs the behavioural and gate-level counters side by side on one stimulus.
//   rstn      : synchronous reset, active low
//   clk       : rising-edge clock
//   x_in      : count enable
//   y_out     : Moore output of the behavioural variant
//   y_out_str : Moore output of the gate-level variant
//   A, B      : state bits of the gate-level variant
module moore_binary_counter (
    input  logic rstn,
    input  logic clk,
    input  logic x_in,
    output logic y_out,
    output logic y_out_str,
    output logic A,
    output logic B
);
    moore_binary_counter_beh u_beh (
        .rstn (rstn),
        .clk  (clk),
        .x_in (x_in),
        .y_out(y_out)
    );
    moore_binary_counter_str u_str (
        .rstn (rstn),
        .clk  (clk),
        .x_in (x_in),
        .y_out(y_out_str),
        .A    (A),
        .B    (B)
    );
endmodule

// File: tb/tb_moore_binary_counter.sv
// tb_moore_binary_counter: scoreboard bench comparing both counter variants against a modulo-4 model.
module tb_moore_binary_counter;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic x_in = 1'b0;
    logic y_out;
    logic y_out_str;
    logic A;
    logic B;

    int total = 0;
    int bad = 0;
    int count = 0;
    bit known = 1'b0;
    int exp_q[$];

    moore_binary_counter dut (
        .rstn     (rstn),
        .clk      (clk),
        .x_in     (x_in),
        .y_out    (y_out),
        .y_out_str(y_out_str),
        .A        (A),
        .B        (B)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one edge, then advance the reference count and queue the expected state.
    task automatic step(input bit r, input bit x);
        @(negedge clk);
        rstn = r;
        x_in = x;
        @(posedge clk);
        if (!r) begin
            count = 0;
            known = 1'b1;
        end else if (known) begin
            count = (count + int'(x)) % 4;
        end
        if (known) exp_q.push_back(count);
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state_ab", int'({A, B}), e);
                check("y_beh", int'(y_out), int'(e == 3));
                check("y_str", int'(y_out_str), int'(e == 3));
            end
        end
    end

    initial begin : driver
        step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, (i % 2) == 0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        for (int i = 0; i < 64; i++) step($urandom_range(0, 15) != 0, 1'($urandom));
        step(1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
